// File: rtl/cpu_trace_pkg.sv
// Shared types and record layout for the CPU io_out trace monitor.
// A record is packed as {ts, pc, io} with io in the low bits; the ts field
// only exists when CPU_IO_TRACE_TIMESTAMP_EN is defined.
package cpu_trace_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int PC_W = 32;
  localparam int IO_W = 32;

  localparam int IO_LSB     = 0;
  localparam int PC_LSB     = IO_W;
  localparam int TS_LSB     = IO_W + PC_W;
  localparam int BASE_REC_W = PC_W + IO_W;

endpackage

// File: rtl/trace_fifo.sv
// Small register-array FIFO with first-word fall-through read.
// A pop is ignored while empty; a push while full is only taken when a pop
// frees a slot in the same cycle, otherwise it is dropped.
module trace_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Occupancy tracks the net effect of push and pop in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head is masked to zero when empty so stale entries never leak out.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/cpu_io_trace.sv
// Output-side monitor for pipelinecpu: every io_out change becomes a
// {pc, io_out, ts} record queued for a valid/ready consumer, with a sticky
// drop flag and a halt detector on a stuck pc.
// Build option: CPU_IO_TRACE_TIMESTAMP_EN adds the cycle timestamp counter
// and widens the record; without it rec_ts is tied to zero.
module cpu_io_trace
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int TS_W        = 16,
  parameter int HALT_CYCLES = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [PC_W-1:0]        pc,
  input  logic [IO_W-1:0]        io_out,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [PC_W-1:0]        rec_pc,
  output logic [IO_W-1:0]        rec_io,
  output logic [TS_W-1:0]        rec_ts,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   halted
);

`ifdef CPU_IO_TRACE_TIMESTAMP_EN
  localparam int REC_W = BASE_REC_W + TS_W;
`else
  localparam int REC_W = BASE_REC_W;
`endif
  localparam int SW = $clog2(HALT_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(HALT_CYCLES);

  state_e            state_q, state_d;
  logic [IO_W-1:0]   io_q, io_d;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [REC_W-1:0]  wr_rec;
  logic [REC_W-1:0]  rd_rec;
  logic              overflow_q;
  logic [PC_W-1:0]   pc_q;
  logic [SW-1:0]     stable_q;

  // FSM state and io_out shadow register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_INIT;
      io_q    <= '0;
    end else begin
      state_q <= state_d;
      io_q    <= io_d;
    end
  end

  // INIT baselines the shadow without a record; RUN pushes on any change.
  always_comb begin
    state_d = state_q;
    io_d    = io_q;
    push    = 1'b0;
    case (state_q)
      ST_INIT: begin
        io_d    = io_out;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (io_out != io_q) begin
          io_d = io_out;
          push = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

`ifdef CPU_IO_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running cycle stamp, zero on the first RUN cycle, silent wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      ts_q <= '0;
    end else if (state_q == ST_RUN) begin
      ts_q <= ts_q + 1'b1;
    end
  end

  assign wr_rec = {ts_q, pc, io_out};
  assign rec_ts = rd_rec[TS_LSB +: TS_W];
`else
  assign wr_rec = {pc, io_out};
  assign rec_ts = '0;
`endif

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push_i    (push),
    .wr_data_i (wr_rec),
    .pop_i     (rec_ready),
    .rd_data_o (rd_rec),
    .count_o   (count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign rec_valid = !fifo_empty;
  assign rec_pc    = rd_rec[PC_LSB +: PC_W];
  assign rec_io    = rd_rec[IO_LSB +: IO_W];

  // Sticky drop flag: a push into a full FIFO with no pop to make room.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (push && fifo_full && !(rec_valid && rec_ready)) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;

  // Count consecutive edges with an unchanged pc, saturating at the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= '0;
      stable_q <= '0;
    end else begin
      pc_q <= pc;
      if (pc != pc_q) begin
        stable_q <= '0;
      end else if (stable_q != STABLE_MAX) begin
        stable_q <= stable_q + 1'b1;
      end
    end
  end

  assign halted = (stable_q == STABLE_MAX);

endmodule

// File: doc/cpu_io_trace.md
# cpu_io_trace

Synthesizable monitor that sits on the output side of `pipelinecpu`, the opposite end of the stimulus path that drives the CPU's clock and reset. It watches `pc` and `io_out`, and turns every change of `io_out` into a trace record. Records are buffered in a small FIFO and handed to a downstream consumer (UART bridge, on-chip logger) over a valid/ready handshake. It also flags when the CPU has halted, meaning it is spinning on a fixed `pc`.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `TS_W`, 16, timestamp width in bits
- `HALT_CYCLES`, 16, consecutive cycles of unchanged `pc` that assert `halted`; ≥2
- `clock`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `pc`  in  32  CPU program counter
- `io_out`  in  32  CPU output port
- `rec_valid`  out  1  head record available
- `rec_ready`  in  1  consumer accepts head record
- `rec_pc`  out  32  `pc` sampled with the event
- `rec_io`  out  32  new `io_out` value
- `rec_ts`  out  TS_W  cycle timestamp of the event (see Configuration)
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy
- `overflow`  out  1  sticky: a record was dropped
- `halted`  out  1  `pc` has been stable for ≥HALT_CYCLES

One clock; reset is synchronous and active-high.

## Operation
- Control FSM has two states, INIT and RUN. Reset forces INIT.
- **INIT**, one cycle:
  - loads shadow register `io_q` ← `io_out`;
  - emits no record;
  - moves to RUN.
- **RUN**, each cycle:
  - if `io_out != io_q`, push {pc, io_out, ts} and set `io_q` ← `io_out`.
- **Push when full** (`count==DEPTH`) with no pop in the same cycle:
  - the record is dropped;
  - `io_q` still updates;
  - `overflow` ← 1.
  - `overflow` clears only on reset.
- **Simultaneous push and pop when full:** both are accepted; `count` stays at DEPTH; no overflow.
- **Simultaneous push and pop when empty:** the pop is ignored because `rec_valid` is 0; the push lands; `count` becomes 1.
- **Pop:** occurs when `rec_valid && rec_ready` at an edge. Head advances; pointers wrap modulo DEPTH.
- **Timestamp counter `ts`:** free-running, 0 on the first RUN cycle, +1 per cycle, wraps at 2^TS_W with no flag.
- **Halt detect:**
  - `pc_q` ← `pc` every cycle.
  - `stable` counter increments (saturating at HALT_CYCLES) while `pc==pc_q`; it resets to 0 on any difference.
  - `halted` = (`stable`==HALT_CYCLES).
  - `halted` is active in INIT and RUN.

## Timing
- **Reset values:**
  - `rec_valid`=0, `count`=0, `overflow`=0, `halted`=0;
  - `rec_pc`/`rec_io`/`rec_ts`=0;
  - `ts`=0, `stable`=0, `io_q`=0, `pc_q`=0, FIFO pointers=0.
- **Latency:** an `io_out` change sampled at edge n is visible with `rec_valid`=1 and the record on the `rec_*` outputs after edge n (first-word fall-through, registered storage).
- `rec_*` are the head entry. They hold stable while `rec_valid && !rec_ready`.
- `count` and `overflow` update at the same edge as the push or pop.
- `halted` rises at the edge where `stable` reaches HALT_CYCLES. It falls one edge after `pc` changes.
- **Reset mid-operation:** the FIFO is flushed and the next `io_out` is re-baselined without generating a record.

## Configuration
- `CPU_IO_TRACE_TIMESTAMP_EN` defined:
  - `ts` counter is instantiated;
  - FIFO width is 64+TS_W;
  - `rec_ts` carries the event timestamp.
- `CPU_IO_TRACE_TIMESTAMP_EN` undefined:
  - no counter;
  - FIFO width is 64;
  - `rec_ts` is tied to 0.
- The port list is identical in both builds.

## Structure
- Shared package `cpu_trace_pkg`:
  - FSM state encoding (INIT/RUN);
  - record field widths (PC_W=32, IO_W=32);
  - record packing offsets.
- One sub-module, `trace_fifo` (parameterized WIDTH, DEPTH):
  - register array with wrap pointers;
  - `count`, `full`, `empty`;
  - first-word fall-through read.
- The top contains the FSM, change detect, timestamp counter, halt detect, and overflow flag.

## Test plan
- Reset, then `io_out`=0x5 held:
  - no record after the INIT cycle;
  - `rec_valid`=0, `count`=0.
- After INIT, `io_out` 0x5→0xA at `pc`=0x40:
  - next cycle `rec_valid`=1, `rec_pc`=0x40, `rec_io`=0xA;
  - with `_EN` defined, `rec_ts` equals the RUN cycle index.
- `rec_ready`=0 and 9 distinct `io_out` changes, DEPTH=8:
  - `count`=8, `overflow`=1;
  - drained records are the first 8 values, in order.
- Full FIFO with `rec_ready`=1 and an `io_out` change in the same cycle:
  - `count` stays 8, `overflow` stays 0;
  - the new record is last out.
- `pc` held at 0x100 for 16 cycles:
  - `halted`=1 on the 16th stable edge;
  - `pc` changes to 0x104 → `halted`=0 next edge.
- Assert `reset` while `count`=3:
  - next edge `count`=0, `rec_valid`=0, `overflow`=0;
  - the first post-reset `io_out` value produces no record.
